// File: rtl/mc6502_bus_pkg.sv
// Shared definitions for the MC6502 bus responder: vector addresses, timer register map,
// bus FSM encoding and the address decoder.
package mc6502_bus_pkg;

    localparam logic [15:0] NMI_VEC_ADDR = 16'hFFFA;
    localparam logic [15:0] RST_VEC_ADDR = 16'hFFFC;
    localparam logic [15:0] IRQ_VEC_ADDR = 16'hFFFE;

    localparam logic [1:0] TMR_TLO  = 2'd0;
    localparam logic [1:0] TMR_THI  = 2'd1;
    localparam logic [1:0] TMR_CTRL = 2'd2;
    localparam logic [1:0] TMR_STAT = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int STAT_PEND_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        REG_VEC  = 2'd0,
        REG_TMR  = 2'd1,
        REG_RAM  = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    // Decode in priority order: vectors shadow everything, then the timer, then RAM.
    function automatic region_t decode_region(input logic [15:0] ab,
                                              input logic [15:0] io_base,
                                              input int          ram_aw);
        if (ab >= NMI_VEC_ADDR)
            return REG_VEC;
        if (ab[15:2] == io_base[15:2])
            return REG_TMR;
        if ((ab >> ram_aw) == 16'd0)
            return REG_RAM;
        return REG_NONE;
    endfunction

    function automatic logic [7:0] vector_byte(input logic [15:0] ab,
                                               input logic [15:0] nmi,
                                               input logic [15:0] rst,
                                               input logic [15:0] irq);
        logic [15:0] vec;
        if ({ab[15:1], 1'b0} == NMI_VEC_ADDR)
            vec = nmi;
        else if ({ab[15:1], 1'b0} == RST_VEC_ADDR)
            vec = rst;
        else if ({ab[15:1], 1'b0} == IRQ_VEC_ADDR)
            vec = irq;
        else
            vec = 16'hFFFF;
        return ab[0] ? vec[15:8] : vec[7:0];
    endfunction

endpackage

// File: rtl/mc6502_interval_timer.sv
// 16-bit reloading down-counter with a sticky pending flag and a registered
// active-low interrupt request.
module mc6502_interval_timer
    import mc6502_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_x,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_x
);

    logic [7:0]  tlo;
    logic [7:0]  thi;
    logic        en;
    logic        ie;
    logic        pend;
    logic [15:0] count;
    logic        underflow;
    logic        wr_tlo;
    logic        wr_thi;
    logic        wr_ctrl;
    logic        wr_stat;

    assign underflow = en && (count == 16'd0);
    assign wr_tlo    = wr && (addr == TMR_TLO);
    assign wr_thi    = wr && (addr == TMR_THI);
    assign wr_ctrl   = wr && (addr == TMR_CTRL);
    assign wr_stat   = wr && (addr == TMR_STAT);

    // A THI write reloads the counter even on an underflow edge; setting PEND beats clearing it.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            tlo   <= 8'h00;
            thi   <= 8'h00;
            en    <= 1'b0;
            ie    <= 1'b0;
            pend  <= 1'b0;
            count <= 16'h0000;
            irq_x <= 1'b1;
        end else begin
            if (wr_tlo)
                tlo <= wdata;
            if (wr_thi)
                thi <= wdata;
            if (wr_ctrl) begin
                en <= wdata[CTRL_EN_BIT];
                ie <= wdata[CTRL_IE_BIT];
            end

            if (wr_thi)
                count <= {wdata, tlo};
            else if (underflow)
                count <= {thi, tlo};
            else if (en)
                count <= count - 16'd1;

            if (underflow)
                pend <= 1'b1;
            else if (wr_stat && wdata[STAT_PEND_BIT])
                pend <= 1'b0;

            irq_x <= ~(pend & ie);
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            TMR_TLO:  rdata = tlo;
            TMR_THI:  rdata = thi;
            TMR_CTRL: begin
                rdata[CTRL_EN_BIT] = en;
                rdata[CTRL_IE_BIT] = ie;
            end
            default:  rdata[STAT_PEND_BIT] = pend;
        endcase
    end

endmodule

// File: rtl/mc6502_bus_responder.sv
// Responder side of the MC6502 bus: decodes core accesses into RAM, vector ROM and the
// interval timer, inserts RAM wait states and counts opcode fetches.
module mc6502_bus_responder
    import mc6502_bus_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] IO_BASE = 16'h8000,
    parameter int          WAIT_N  = 0,
    parameter logic [15:0] RST_VEC = 16'hF000,
    parameter logic [15:0] NMI_VEC = 16'hF000,
    parameter logic [15:0] IRQ_VEC = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic [15:0] i_ab,
    input  logic        i_rw,
    input  logic        i_sync,
    input  logic [7:0]  i_db,
    output logic [7:0]  o_db,
    output logic        o_rdy,
    output logic        o_irq_x,
    output logic [15:0] o_fetches
);

    localparam int         RAM_DEPTH = 1 << RAM_AW;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_N - 1);

    bus_state_t        state;
    logic [2:0]        wait_cnt;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              rw_q;
    logic              sync_q;
    logic [7:0]        db_q;

    logic [7:0]        ram [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;

    region_t           region;
    logic              stall_start;
    logic              wait_done;
    logic              idle_access;
    logic [7:0]        read_mux;
    logic [7:0]        tmr_rdata;
    logic              tmr_wr;

    assign region      = decode_region(i_ab, IO_BASE, RAM_AW);
    assign stall_start = (state == IDLE) && (region == REG_RAM) && (WAIT_N != 0);
    assign wait_done   = (state == WAIT) && (wait_cnt == WAIT_LAST);
    assign idle_access = (state == IDLE) && !stall_start;

    // In WAIT the RAM port works from the access latched at the sampling edge.
    assign ram_addr  = (state == WAIT) ? ram_addr_q : i_ab[RAM_AW-1:0];
    assign ram_wdata = (state == WAIT) ? db_q : i_db;
    assign ram_we    = rst_x && ((idle_access && (region == REG_RAM) && !i_rw) ||
                                 (wait_done && !rw_q));

    assign tmr_wr = idle_access && (region == REG_TMR) && !i_rw;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
    end

    always_comb begin
        read_mux = 8'hFF;
        case (region)
            REG_VEC: read_mux = vector_byte(i_ab, NMI_VEC, RST_VEC, IRQ_VEC);
            REG_TMR: read_mux = tmr_rdata;
            REG_RAM: read_mux = ram[ram_addr];
            default: read_mux = 8'hFF;
        endcase
    end

    // Wait FSM; o_db only changes when a read completes, so writes leave it holding.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            ram_addr_q <= '0;
            rw_q       <= 1'b1;
            sync_q     <= 1'b0;
            db_q       <= 8'h00;
            o_db       <= 8'h00;
            o_rdy      <= 1'b1;
            o_fetches  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    ram_addr_q <= i_ab[RAM_AW-1:0];
                    rw_q       <= i_rw;
                    sync_q     <= i_sync;
                    db_q       <= i_db;
                    if (stall_start) begin
                        state    <= WAIT;
                        wait_cnt <= 3'd0;
                        o_rdy    <= 1'b0;
                    end else if (i_rw) begin
                        o_db <= read_mux;
                        if (i_sync)
                            o_fetches <= o_fetches + 16'd1;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        state <= DATA;
                        o_rdy <= 1'b1;
                        if (rw_q) begin
                            o_db <= ram[ram_addr];
                            if (sync_q)
                                o_fetches <= o_fetches + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DATA: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mc6502_interval_timer timer (
        .clk   (clk),
        .rst_x (rst_x),
        .wr    (tmr_wr),
        .addr  (i_ab[1:0]),
        .wdata (i_db),
        .rdata (tmr_rdata),
        .irq_x (o_irq_x)
    );

endmodule

// File: tb/tb_mc6502_bus_responder.sv
// Scoreboard bench for mc6502_bus_responder: one zero-wait instance with distinct NMI/IRQ
// vectors and one two-wait-state instance with default vectors.
module tb_mc6502_bus_responder;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [15:0] ab0, ab2;
    logic        rw0, rw2, sync0, sync2;
    logic [7:0]  db0, db2;
    logic [7:0]  odb0, odb2;
    logic        rdy0, rdy2, irq0, irq2;
    logic [15:0] fet0, fet2;

    int          checks = 0;
    int          fails = 0;
    logic        rdy0Dropped = 1'b0;
    expect_t     expQ[$];

    always #5 clk = ~clk;

    mc6502_bus_responder #(
        .RAM_AW(11), .IO_BASE(16'h8000), .WAIT_N(0),
        .RST_VEC(16'hF000), .NMI_VEC(16'hC3A5), .IRQ_VEC(16'hD2B4)
    ) dut0 (
        .clk(clk), .rst_x(rst_x), .i_ab(ab0), .i_rw(rw0), .i_sync(sync0), .i_db(db0),
        .o_db(odb0), .o_rdy(rdy0), .o_irq_x(irq0), .o_fetches(fet0)
    );

    mc6502_bus_responder #(
        .RAM_AW(11), .IO_BASE(16'h8000), .WAIT_N(2),
        .RST_VEC(16'hF000), .NMI_VEC(16'hF000), .IRQ_VEC(16'hF000)
    ) dut2 (
        .clk(clk), .rst_x(rst_x), .i_ab(ab2), .i_rw(rw2), .i_sync(sync2), .i_db(db2),
        .o_db(odb2), .o_rdy(rdy2), .o_irq_x(irq2), .o_fetches(fet2)
    );

    // The zero-wait instance must never pull ready low while out of reset.
    always @(negedge clk) begin
        if (rst_x === 1'b1 && rdy0 !== 1'b1)
            rdy0Dropped = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [15:0] ab, input logic rw,
                                 input logic [7:0] db, input logic sync);
        if (sel == 0) begin
            ab0 = ab; rw0 = rw; db0 = db; sync0 = sync;
        end else begin
            ab2 = ab; rw2 = rw; db2 = db; sync2 = sync;
        end
    endtask

    // Unmapped write: ignored by the design and leaves o_db and the fetch count alone.
    task automatic setNeutral(input int sel);
        applyStimulus(sel, 16'h4000, 1'b0, 8'h00, 1'b0);
    endtask

    // Called just after a falling edge; returns just after the falling edge where the
    // next access can be presented.
    task automatic busCycle(input int sel, input logic [15:0] ab, input logic rw,
                            input logic [7:0] db, input logic sync, input logic [7:0] expData,
                            input int expStall, input string tag);
        int      stalls;
        logic    ready;
        expect_t e;
        stalls = 0;
        applyStimulus(sel, ab, rw, db, sync);
        if (rw) begin
            e.tag   = tag;
            e.value = expData;
            expQ.push_back(e);
        end
        while (stalls <= 12) begin
            @(negedge clk);
            ready = (sel == 0) ? rdy0 : rdy2;
            if (ready === 1'b1)
                break;
            stalls++;
        end
        setNeutral(sel);
        checkOutput({tag, "_stall"}, stalls, expStall);
        if (rw && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, 32'((sel == 0) ? odb0 : odb2), 32'(e.value));
        end
        if (stalls > 0)
            @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        rst_x = 1'b0;
        setNeutral(0);
        setNeutral(1);
        repeat (2) @(negedge clk);
        checkOutput("rst_db", 32'(odb0), 32'h00);
        checkOutput("rst_rdy0", 32'(rdy0), 32'h1);
        checkOutput("rst_rdy2", 32'(rdy2), 32'h1);
        checkOutput("rst_irq", 32'(irq0), 32'h1);
        checkOutput("rst_fetches", 32'(fet0), 32'h0);
        rst_x = 1'b1;
        @(negedge clk);

        $display("[TB] zero-wait RAM and decode");
        busCycle(0, 16'h0010, 1'b0, 8'h5A, 1'b0, 8'h00, 0, "t1_wr");
        busCycle(0, 16'h0010, 1'b1, 8'h00, 1'b0, 8'h5A, 0, "t1_rd");
        busCycle(0, 16'h07FF, 1'b0, 8'hC7, 1'b0, 8'h00, 0, "t1_wr_top");
        busCycle(0, 16'h07FF, 1'b1, 8'h00, 1'b0, 8'hC7, 0, "t1_rd_top");
        busCycle(0, 16'h0800, 1'b1, 8'h00, 1'b0, 8'hFF, 0, "t1_rd_above_ram");
        busCycle(0, 16'h4000, 1'b1, 8'h00, 1'b0, 8'hFF, 0, "t4_unmapped");
        busCycle(0, 16'hFFFA, 1'b0, 8'h00, 1'b0, 8'h00, 0, "t4_wr_vec");
        busCycle(0, 16'hFFFA, 1'b1, 8'h00, 1'b0, 8'hA5, 0, "t4_nmi_lo");
        busCycle(0, 16'hFFFB, 1'b1, 8'h00, 1'b0, 8'hC3, 0, "t4_nmi_hi");
        busCycle(0, 16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00, 0, "t4_rst_lo");
        busCycle(0, 16'hFFFD, 1'b1, 8'h00, 1'b0, 8'hF0, 0, "t4_rst_hi");
        busCycle(0, 16'hFFFE, 1'b1, 8'h00, 1'b0, 8'hB4, 0, "t4_irq_lo");
        busCycle(0, 16'hFFFF, 1'b1, 8'h00, 1'b0, 8'hD2, 0, "t4_irq_hi");

        $display("[TB] fetch counter");
        busCycle(0, 16'h0010, 1'b1, 8'h00, 1'b1, 8'h5A, 0, "t5_f1");
        busCycle(0, 16'hFFFC, 1'b1, 8'h00, 1'b1, 8'h00, 0, "t5_f2");
        busCycle(0, 16'h4000, 1'b1, 8'h00, 1'b1, 8'hFF, 0, "t5_f3");
        busCycle(0, 16'h0010, 1'b1, 8'h00, 1'b0, 8'h5A, 0, "t5_nosync");
        checkOutput("t5_fetch3", 32'(fet0), 32'd3);
        applyStimulus(0, 16'h4000, 1'b1, 8'h00, 1'b1);
        repeat (65532) @(negedge clk);
        setNeutral(0);
        checkOutput("t5_fetch_max", 32'(fet0), 32'hFFFF);
        busCycle(0, 16'h4000, 1'b1, 8'h00, 1'b1, 8'hFF, 0, "t5_fwrap_rd");
        checkOutput("t5_fetch_wrap", 32'(fet0), 32'h0);

        $display("[TB] interval timer");
        busCycle(0, 16'h8002, 1'b0, 8'hFC, 1'b0, 8'h00, 0, "t3_wr_ctrl_hi");
        busCycle(0, 16'h8002, 1'b1, 8'h00, 1'b0, 8'h00, 0, "t3_ctrl_mask");
        busCycle(0, 16'h8000, 1'b0, 8'h03, 1'b0, 8'h00, 0, "t3_wr_tlo");
        busCycle(0, 16'h8001, 1'b0, 8'h00, 1'b0, 8'h00, 0, "t3_wr_thi");
        busCycle(0, 16'h8000, 1'b1, 8'h00, 1'b0, 8'h03, 0, "t3_rd_tlo");
        busCycle(0, 16'h8001, 1'b1, 8'h00, 1'b0, 8'h00, 0, "t3_rd_thi");
        busCycle(0, 16'h8002, 1'b0, 8'h03, 1'b0, 8'h00, 0, "t3_wr_ctrl");
        // Counter 3 -> underflow four edges after enable, irq one edge later.
        cnt = 0;
        while (irq0 === 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t3_irq_delay", cnt, 5);
        busCycle(0, 16'h8003, 1'b1, 8'h00, 1'b0, 8'h01, 0, "t3_stat_pend");
        busCycle(0, 16'h8003, 1'b0, 8'h01, 1'b0, 8'h00, 0, "t3_wr_clear");
        @(negedge clk);
        checkOutput("t3_irq_cleared", 32'(irq0), 32'h1);
        repeat (3) @(negedge clk);
        busCycle(0, 16'h8003, 1'b0, 8'h01, 1'b0, 8'h00, 0, "t3_wr_clear_race");
        @(negedge clk);
        checkOutput("t3_irq_race", 32'(irq0), 32'h0);
        busCycle(0, 16'h8003, 1'b1, 8'h00, 1'b0, 8'h01, 0, "t3_stat_race");

        $display("[TB] wait-state instance");
        busCycle(1, 16'h0020, 1'b0, 8'h3C, 1'b0, 8'h00, 2, "t2_wr");
        busCycle(1, 16'h0020, 1'b1, 8'h00, 1'b0, 8'h3C, 2, "t2_rd");
        busCycle(1, 16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00, 0, "t2_vec_lo");
        busCycle(1, 16'h4000, 1'b1, 8'h00, 1'b0, 8'hFF, 0, "t2_unmapped");
        busCycle(1, 16'hFFFD, 1'b1, 8'h00, 1'b0, 8'hF0, 0, "t2_vec_hi");
        busCycle(1, 16'h0020, 1'b1, 8'h00, 1'b1, 8'h3C, 2, "t2_rd_sync");
        checkOutput("t2_fetch1", 32'(fet2), 32'd1);

        $display("[TB] reset during wait");
        busCycle(1, 16'h0030, 1'b0, 8'h77, 1'b0, 8'h00, 2, "t6_wr");
        busCycle(1, 16'h0030, 1'b1, 8'h00, 1'b0, 8'h77, 2, "t6_rd");
        applyStimulus(1, 16'h0030, 1'b0, 8'h11, 1'b0);
        @(negedge clk);
        checkOutput("t6_in_wait", 32'(rdy2), 32'h0);
        #2;
        rst_x = 1'b0;
        setNeutral(1);
        #1;
        checkOutput("t6_rst_rdy", 32'(rdy2), 32'h1);
        checkOutput("t6_rst_db", 32'(odb2), 32'h00);
        checkOutput("t6_rst_irq", 32'(irq2), 32'h1);
        checkOutput("t6_rst_fetches", 32'(fet2), 32'h0);
        checkOutput("t6_rst_db0", 32'(odb0), 32'h00);
        repeat (2) @(negedge clk);
        rst_x = 1'b1;
        busCycle(1, 16'h0030, 1'b1, 8'h00, 1'b0, 8'h77, 2, "t6_ram_kept");

        checkOutput("t1_rdy_never_low", 32'(rdy0Dropped), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
